multimode_register: RTL and testbench

- Parametrised successor to the team's 8-bit load register.
- Holds one WIDTH-bit value and supports per-lane masked load, increment/decrement with carry, and multi-cycle shift/rotate by a programmable amount.
- Commands are accepted through a valid/ready handshake, and completion is reported with a single-cycle done pulse.
- Used as a general-purpose datapath register under sequencer control.

---
 rtl/multimode_register.sv | 190 +++++++++++++++++++
 tb/tb_multimode_register.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multimode_register.sv
`default_nettype none
// ============================================================================
// Module      : multimode_register
// Description : WIDTH-bit datapath register with per-lane masked load,
//               increment/decrement with carry, and multi-cycle shift/rotate
//               by a programmable amount. Commands use a valid/ready
//               handshake; completion is reported with a one-cycle done.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module multimode_register #(
  parameter int               WIDTH     = 8,   // power of 2, >= 2
  parameter int               LANE      = 8,   // WIDTH must be a multiple
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       reset,     // asynchronous, active low
  input  logic [2:0]                 op,
  input  logic                       op_valid,
  output logic                       op_ready,
  input  logic [WIDTH-1:0]           data_in,
  input  logic [WIDTH/LANE-1:0]      lane_en,
  input  logic                       ser_in,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  output logic [WIDTH-1:0]           data_out,
  output logic                       carry,
  output logic                       zero,
  output logic                       done
);

  localparam int NL = WIDTH / LANE;
  localparam int SW = $clog2(WIDTH);

  localparam logic [2:0] c_op_nop  = 3'b000;
  localparam logic [2:0] c_op_load = 3'b001;
  localparam logic [2:0] c_op_inc  = 3'b010;
  localparam logic [2:0] c_op_dec  = 3'b011;

  // Low two opcode bits select the shift flavour once op[2] is set.
  localparam logic [1:0] c_sh_shl = 2'b00;
  localparam logic [1:0] c_sh_shr = 2'b01;
  localparam logic [1:0] c_sh_rol = 2'b10;
  localparam logic [1:0] c_sh_ror = 2'b11;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t           r_state,        w_state_nxt;
  logic [WIDTH-1:0] r_data,         w_data_nxt;
  logic             r_carry,        w_carry_nxt;
  logic             r_done,         w_done_nxt;
  logic [SW-1:0]    r_remaining,    w_remaining_nxt;
  logic [1:0]       r_shift_kind,   w_shift_kind_nxt;

  logic [WIDTH-1:0] w_lane_mask;
  logic [1:0]       w_step_kind;
  logic [WIDTH-1:0] w_step_data;
  logic             w_step_carry;
  logic [WIDTH:0]   w_inc;
  logic [WIDTH:0]   w_dec;

  // Expand the per-lane enables into a bit mask over the register.
  generate
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
      assign w_lane_mask[gi*LANE +: LANE] = {LANE{lane_en[gi]}};
    end
  endgenerate

  // Extra MSB captures carry-out on increment and borrow on decrement.
  assign w_inc = {1'b0, r_data} + (WIDTH+1)'(1);
  assign w_dec = {1'b0, r_data} - (WIDTH+1)'(1);

  // While shifting, the latched flavour drives the step; in IDLE the new op does.
  assign w_step_kind = (r_state == S_SHIFT) ? r_shift_kind : op[1:0];

  // One-bit shift/rotate step of the current register value.
  always_comb begin
    w_step_data  = r_data;
    w_step_carry = 1'b0;
    case (w_step_kind)
      c_sh_shl: begin
        w_step_data  = {r_data[WIDTH-2:0], ser_in};
        w_step_carry = r_data[WIDTH-1];
      end
      c_sh_shr: begin
        w_step_data  = {ser_in, r_data[WIDTH-1:1]};
        w_step_carry = r_data[0];
      end
      c_sh_rol: begin
        w_step_data  = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
        w_step_carry = r_data[WIDTH-1];
      end
      c_sh_ror: begin
        w_step_data  = {r_data[0], r_data[WIDTH-1:1]};
        w_step_carry = r_data[0];
      end
      default: begin
        w_step_data  = r_data;
        w_step_carry = 1'b0;
      end
    endcase
  end

  // Next-state, datapath update and done generation.
  always_comb begin
    w_state_nxt      = r_state;
    w_data_nxt       = r_data;
    w_carry_nxt      = r_carry;
    w_done_nxt       = 1'b0;
    w_remaining_nxt  = r_remaining;
    w_shift_kind_nxt = r_shift_kind;
    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          w_done_nxt = 1'b1;
          case (op)
            c_op_nop: begin
              w_data_nxt = r_data;
            end
            c_op_load: begin
              w_data_nxt = (r_data & ~w_lane_mask) | (data_in & w_lane_mask);
            end
            c_op_inc: begin
              w_data_nxt  = w_inc[WIDTH-1:0];
              w_carry_nxt = w_inc[WIDTH];
            end
            c_op_dec: begin
              w_data_nxt  = w_dec[WIDTH-1:0];
              w_carry_nxt = w_dec[WIDTH];
            end
            default: begin
              // Shift/rotate: amount 0 is a pure handshake, 1 finishes now,
              // larger amounts do the first bit here and continue in SHIFT.
              if (shamt != '0) begin
                w_data_nxt  = w_step_data;
                w_carry_nxt = w_step_carry;
                if (shamt != SW'(1)) begin
                  w_done_nxt       = 1'b0;
                  w_state_nxt      = S_SHIFT;
                  w_remaining_nxt  = shamt - SW'(1);
                  w_shift_kind_nxt = op[1:0];
                end
              end
            end
          endcase
        end
      end
      S_SHIFT: begin
        w_data_nxt      = w_step_data;
        w_carry_nxt     = w_step_carry;
        w_remaining_nxt = r_remaining - SW'(1);
        if (r_remaining == SW'(1)) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any shift in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_data       <= RESET_VAL;
      r_carry      <= 1'b0;
      r_done       <= 1'b0;
      r_remaining  <= '0;
      r_shift_kind <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_data       <= w_data_nxt;
      r_carry      <= w_carry_nxt;
      r_done       <= w_done_nxt;
      r_remaining  <= w_remaining_nxt;
      r_shift_kind <= w_shift_kind_nxt;
    end
  end

  assign op_ready = (r_state == S_IDLE);
  assign data_out = r_data;
  assign carry    = r_carry;
  assign done     = r_done;
  assign zero     = (r_data == '0);

endmodule
`default_nettype wire

// File: tb/tb_multimode_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_multimode_register
// Description : Directed bench for multimode_register. An 8-bit and a 16-bit
//               instance share clock and reset. Expected results are queued
//               when a command is issued and checked whenever done pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multimode_register;

  localparam logic [2:0] c_nop  = 3'b000;
  localparam logic [2:0] c_load = 3'b001;
  localparam logic [2:0] c_inc  = 3'b010;
  localparam logic [2:0] c_dec  = 3'b011;
  localparam logic [2:0] c_shl  = 3'b100;
  localparam logic [2:0] c_shr  = 3'b101;
  localparam logic [2:0] c_ror  = 3'b111;

  typedef struct {
    logic [15:0] data;
    logic        carry;
  } exp_t;

  logic clk;
  logic rst_n;

  logic [2:0]  op8,  op16;
  logic        valid8, valid16;
  logic        ready8, ready16;
  logic [7:0]  din8;
  logic [15:0] din16;
  logic [0:0]  lane8;
  logic [1:0]  lane16;
  logic        ser8, ser16;
  logic [2:0]  sh8;
  logic [3:0]  sh16;
  logic [7:0]  dout8;
  logic [15:0] dout16;
  logic        carry8, carry16, zero8, zero16, done8, done16;

  exp_t q8[$];
  exp_t q16[$];

  int n_checks = 0;
  int n_pass   = 0;

  multimode_register #(.WIDTH(8), .LANE(8), .RESET_VAL(8'h00)) u_dut8 (
    .clk(clk), .reset(rst_n), .op(op8), .op_valid(valid8), .op_ready(ready8),
    .data_in(din8), .lane_en(lane8), .ser_in(ser8), .shamt(sh8),
    .data_out(dout8), .carry(carry8), .zero(zero8), .done(done8)
  );

  multimode_register #(.WIDTH(16), .LANE(8), .RESET_VAL(16'h0000)) u_dut16 (
    .clk(clk), .reset(rst_n), .op(op16), .op_valid(valid16), .op_ready(ready16),
    .data_in(din16), .lane_en(lane16), .ser_in(ser16), .shamt(sh16),
    .data_out(dout16), .carry(carry16), .zero(zero16), .done(done16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor: every done pulse must match the oldest queued result.
  always @(negedge clk) begin
    exp_t e;
    if (done8 !== 1'b0) begin
      if (q8.size() == 0) chk("sb8_spurious_done", 32'(done8), 32'h0);
      else begin
        e = q8.pop_front();
        chk("sb8_data",  32'(dout8),  32'(e.data[7:0]));
        chk("sb8_carry", 32'(carry8), 32'(e.carry));
        chk("sb8_zero",  32'(zero8),  32'(e.data[7:0] == 8'h00));
      end
    end
    if (done16 !== 1'b0) begin
      if (q16.size() == 0) chk("sb16_spurious_done", 32'(done16), 32'h0);
      else begin
        e = q16.pop_front();
        chk("sb16_data",  32'(dout16),  32'(e.data));
        chk("sb16_carry", 32'(carry16), 32'(e.carry));
      end
    end
  end

  // Present one command at posedge+1; returns one edge later (posedge+1).
  task automatic issue8(input logic [2:0] o, input logic [7:0] d, input logic le,
                        input logic s, input logic [2:0] sh, input bit push,
                        input logic [7:0] ed, input logic ec);
    exp_t e;
    op8 = o; din8 = d; lane8 = le; ser8 = s; sh8 = sh; valid8 = 1'b1;
    if (push) begin
      e.data = {8'h00, ed}; e.carry = ec;
      q8.push_back(e);
    end
    @(posedge clk); #1;
    valid8 = 1'b0;
  endtask

  task automatic issue16(input logic [2:0] o, input logic [15:0] d, input logic [1:0] le,
                         input logic [15:0] ed, input logic ec);
    exp_t e;
    op16 = o; din16 = d; lane16 = le; ser16 = 1'b0; sh16 = 4'd0; valid16 = 1'b1;
    e.data = ed; e.carry = ec;
    q16.push_back(e);
    @(posedge clk); #1;
    valid16 = 1'b0;
  endtask

  task automatic settle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    op8 = c_nop; din8 = '0; lane8 = '0; ser8 = 1'b0; sh8 = '0; valid8 = 1'b0;
    op16 = c_nop; din16 = '0; lane16 = '0; ser16 = 1'b0; sh16 = '0; valid16 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("por_data",  32'(dout8),  32'h00);
    chk("por_carry", 32'(carry8), 32'h0);
    chk("por_done",  32'(done8),  32'h0);
    chk("por_ready", 32'(ready8), 32'h1);
    chk("por_zero",  32'(zero8),  32'h1);

    // 16-bit lane-masked load, carry preserved across LOAD.
    issue16(c_load, 16'hFFFF, 2'b11, 16'hFFFF, 1'b0);
    issue16(c_inc,  16'h0000, 2'b00, 16'h0000, 1'b1);
    issue16(c_load, 16'h1234, 2'b11, 16'h1234, 1'b1);
    issue16(c_load, 16'hABCD, 2'b10, 16'hAB34, 1'b1);
    chk("t2_done_after_accept", 32'(done16), 32'h1);
    settle(1);
    chk("t2_done_one_cycle", 32'(done16), 32'h0);
    chk("t2_hold", 32'(dout16), 32'hAB34);

    // Asynchronous reset mid-simulation.
    issue8(c_load, 8'h5A, 1'b1, 1'b0, 3'd0, 1'b1, 8'h5A, 1'b0);
    settle(1);
    #3 rst_n = 1'b0;
    #1;
    chk("t1_rst_data",  32'(dout8),  32'h00);
    chk("t1_rst_carry", 32'(carry8), 32'h0);
    chk("t1_rst_done",  32'(done8),  32'h0);
    chk("t1_rst_ready", 32'(ready8), 32'h1);
    chk("t1_rst_zero",  32'(zero8),  32'h1);
    repeat (2) @(posedge clk); #1;
    chk("t1_rst_held", 32'(dout8), 32'h00);
    @(negedge clk) rst_n = 1'b1;
    settle(2);
    chk("t1_post_rel_data",  32'(dout8),  32'h00);
    chk("t1_post_rel_ready", 32'(ready8), 32'h1);

    // Back-to-back INC/DEC wrap and carry.
    issue8(c_load, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b1, 8'hFF, 1'b0);
    issue8(c_inc,  8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 8'h00, 1'b1);
    issue8(c_dec,  8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 8'hFF, 1'b1);
    issue8(c_load, 8'h10, 1'b1, 1'b0, 3'd0, 1'b1, 8'h10, 1'b1);
    issue8(c_inc,  8'h00, 1'b0, 1'b0, 3'd0, 1'b1, 8'h11, 1'b0);
    settle(1);

    // SHL by 3 with ser_in=1 from 0x81.
    issue8(c_load, 8'h81, 1'b1, 1'b0, 3'd0, 1'b1, 8'h81, 1'b0);
    issue8(c_shl,  8'h00, 1'b0, 1'b1, 3'd3, 1'b1, 8'h0F, 1'b0);
    chk("t4_e1_data",  32'(dout8),  32'h03);
    chk("t4_e1_carry", 32'(carry8), 32'h1);
    chk("t4_e1_ready", 32'(ready8), 32'h0);
    settle(1);
    chk("t4_e2_data",  32'(dout8),  32'h07);
    chk("t4_e2_ready", 32'(ready8), 32'h0);
    settle(1);
    chk("t4_e3_data",  32'(dout8),  32'h0F);
    chk("t4_e3_ready", 32'(ready8), 32'h1);
    chk("t4_e3_done",  32'(done8),  32'h1);

    // ROR by 4 from 0xA5 with an ignored LOAD while busy.
    issue8(c_load, 8'hA5, 1'b1, 1'b0, 3'd0, 1'b1, 8'hA5, 1'b0);
    issue8(c_ror,  8'h00, 1'b0, 1'b0, 3'd4, 1'b1, 8'h5A, 1'b0);
    chk("t5_e1_data",  32'(dout8),  32'hD2);
    chk("t5_e1_ready", 32'(ready8), 32'h0);
    op8 = c_load; din8 = 8'h00; lane8 = 1'b1; valid8 = 1'b1;
    settle(1);
    chk("t5_e2_data", 32'(dout8), 32'h69);
    settle(1);
    chk("t5_e3_data", 32'(dout8), 32'hB4);
    valid8 = 1'b0;
    settle(1);
    chk("t5_e4_data",  32'(dout8),  32'h5A);
    chk("t5_e4_ready", 32'(ready8), 32'h1);
    settle(2);
    chk("t5_dropped_load", 32'(dout8), 32'h5A);

    // SHL by 7 aborted by reset before its third edge.
    issue8(c_load, 8'h01, 1'b1, 1'b0, 3'd0, 1'b1, 8'h01, 1'b0);
    issue8(c_shl,  8'h00, 1'b0, 1'b0, 3'd7, 1'b0, 8'h00, 1'b0);
    chk("t6_e1_data", 32'(dout8), 32'h02);
    settle(1);
    chk("t6_e2_data", 32'(dout8), 32'h04);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_abort_data",  32'(dout8),  32'h00);
    chk("t6_abort_ready", 32'(ready8), 32'h1);
    chk("t6_abort_done",  32'(done8),  32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    settle(3);
    chk("t6_after_rel_done", 32'(done8), 32'h0);
    issue8(c_load, 8'hB3, 1'b1, 1'b0, 3'd0, 1'b1, 8'hB3, 1'b0);
    issue8(c_shr,  8'h00, 1'b0, 1'b0, 3'd1, 1'b1, 8'h59, 1'b1);
    issue8(c_shr,  8'h00, 1'b0, 1'b1, 3'd0, 1'b1, 8'h59, 1'b1);
    chk("t6_shamt0_ready", 32'(ready8), 32'h1);
    settle(3);

    chk("sb8_all_done_seen",  32'(q8.size()),  32'h0);
    chk("sb16_all_done_seen", 32'(q16.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
